scsp_dma_ctrl: RTL and testbench
================================

// Module: scsp_dma_ctrl
// PURPOSE
//  Sequencer for the SCSP internal DMA (CR5..CR7: DMEA, DRGA, DTLG, DDIR, DGATE, DEXE).
//  Moves 16-bit words between sound RAM and the SCSP register window (0x100000+).
//  Owns one requester port on the sound-RAM arbiter and one on the register file.
//  Signals completion via a DEXE clear pulse and a DMA-end interrupt pulse.
// PARAMETERS
//  MEM_AW  19  sound-RAM word-address width (byte address [19:1])
//  REG_AW  11  register-window word-address width (byte offset [11:1])
//  LEN_W   11  transfer-length width in words (DTLG)
// PORTS
//  CLK        in   1       system clock
//  RST_N      in   1       asynchronous reset, active low
//  DMEA       in   MEM_AW  sound-RAM start word address {DMEAH,DMEAL}
//  DRGA       in   REG_AW  register-window start word address
//  DTLG       in   LEN_W   transfer length in words
//  DDIR       in   1       0: RAM->reg, 1: reg->RAM
//  DGATE      in   1       1: write zeros, skip source read
//  DEXE       in   1       start strobe (level in CR7; edge-detected internally)
//  DEXE_CLR   out  1       1-cycle pulse at completion: clears CR7.DEXE
//  DMA_IRQ    out  1       1-cycle pulse at completion (SCIPD/MCIPD bit 4 set)
//  BUSY       out  1       high from accepted start to completion
//  MEM_REQ    out  1       sound-RAM access request
//  MEM_WE     out  1       1 = write
//  MEM_A      out  MEM_AW  sound-RAM word address
//  MEM_D      out  16      write data
//  MEM_Q      in   16      read data, valid with MEM_ACK
//  MEM_ACK    in   1       1-cycle access-complete strobe
//  REG_REQ/REG_WE/REG_A[REG_AW]/REG_D[16]/REG_Q[16]/REG_ACK: same protocol on the register port
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, data latch 0. Reset mid-transfer aborts with no completion pulse.
//  Start: DEXE rising edge in IDLE latches DMEA, DRGA, DTLG, DDIR, DGATE into working regs.
//   BUSY rises the next cycle. DEXE edges while BUSY are ignored; register inputs changing during a transfer have no effect.
//  Handshake (both ports): REQ/WE/A/D assert in the same cycle and stay stable until ACK is sampled high.
//   REQ drops in the cycle after ACK. ACK is not expected without REQ; a stray ACK is ignored.
//   REQ never re-asserts in the cycle directly after ACK.
//  FSM states:
//   IDLE  -> LOAD on DEXE edge
//   LOAD  -> DONE if DTLG==0; else RD if !DGATE; else WR (data latch = 0)
//   RD    : source REQ (RAM if DDIR=0, reg if DDIR=1), WE=0; on ACK latch Q -> WR
//   WR    : dest REQ, WE=1, D=latch (0 if DGATE); on ACK -> NEXT
//   NEXT  : both addresses +1, count -1 -> DONE if count==0, else RD (DGATE: WR)
//   DONE  : DEXE_CLR=1, DMA_IRQ=1 for 1 cycle, BUSY=0 -> IDLE
//  Only one port requests at a time. Per-word cost with single-cycle ACK: 2 cycles (RD) + 2 (WR) + 1 (NEXT).
//  Address arithmetic: MEM_A wraps modulo 2^MEM_AW and REG_A wraps modulo 2^REG_AW; no carry between the two.
//  Count: LEN_W-bit down-counter; DTLG max (2^LEN_W-1) transfers exactly that many words.
//  A DEXE edge in the DONE cycle is ignored; a new start needs a fresh rising edge seen in IDLE.
// TESTING
//  T1 DMEA=0x00100,DRGA=0x300,DTLG=4,DDIR=0,DGATE=0, RAM words 1111..4444, ACK after 1 cycle
//     -> reg writes to 0x300..0x303 carry 1111,2222,3333,4444; one DEXE_CLR+DMA_IRQ pulse; BUSY low.
//  T2 DDIR=1,DRGA=0x7FF,DTLG=2,DMEA=0x7FFFF -> reads reg 0x7FF then 0x000; writes RAM 0x7FFFF then 0x00000 (both wrap).
//  T3 DGATE=1,DDIR=0,DTLG=3 -> zero REG_REQ reads and zero MEM_REQ; 3 reg writes of 0x0000; completion pulse.
//  T4 DTLG=0 -> no port requests; DEXE_CLR/DMA_IRQ pulse 2 cycles after the DEXE edge.
//  T5 MEM_ACK delayed 5 cycles; extra DEXE edge and DMEA change mid-transfer
//     -> REQ/A/D stable until ACK; transfer unaffected; exactly one completion pulse.
//  T6 RST_N low while WR pending -> all outputs 0 immediately; after release, a new DEXE edge starts a clean transfer.

Source files
------------

// File: rtl/scsp_dma_ctrl.sv
// SCSP internal DMA sequencer: copies 16-bit words between sound RAM and the
// register window, one word at a time, over two request/ack ports.
module scsp_dma_ctrl #(
  parameter int MEM_AW = 19,
  parameter int REG_AW = 11,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MEM_AW-1:0] dmea,
  input  logic [REG_AW-1:0] drga,
  input  logic [LEN_W-1:0]  dtlg,
  input  logic              ddir,
  input  logic              dgate,
  input  logic              dexe,
  output logic              dexe_clr,
  output logic              dma_irq,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_a,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q,
  input  logic              mem_ack,
  output logic              reg_req,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_a,
  output logic [15:0]       reg_d,
  input  logic [15:0]       reg_q,
  input  logic              reg_ack
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RD, S_WR, S_NEXT, S_DONE} state_t;

  state_t            state;
  logic              dexe_q;
  logic [MEM_AW-1:0] maddr;
  logic [REG_AW-1:0] raddr;
  logic [LEN_W-1:0]  cnt;
  logic              dir, gate;
  logic [15:0]       dat;

  // dir=0: RAM is source, register window is destination; dir=1 swaps them
  logic        src_req, src_ack, dst_req, dst_ack;
  logic [15:0] src_q;
  assign src_req = dir ? reg_req : mem_req;
  assign src_ack = dir ? reg_ack : mem_ack;
  assign src_q   = dir ? reg_q   : mem_q;
  assign dst_req = dir ? mem_req : reg_req;
  assign dst_ack = dir ? mem_ack : reg_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dexe_q   <= 1'b0;
      maddr    <= '0;
      raddr    <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
      gate     <= 1'b0;
      dat      <= '0;
      dexe_clr <= 1'b0;
      dma_irq  <= 1'b0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_d    <= '0;
      reg_req  <= 1'b0;
      reg_we   <= 1'b0;
      reg_a    <= '0;
      reg_d    <= '0;
    end else begin
      dexe_q   <= dexe;
      dexe_clr <= 1'b0;
      dma_irq  <= 1'b0;
      case (state)
        S_IDLE: if (dexe && !dexe_q) begin
          maddr <= dmea;
          raddr <= drga;
          cnt   <= dtlg;
          dir   <= ddir;
          gate  <= dgate;
          busy  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          dat <= '0;
          if (cnt == '0) begin
            busy     <= 1'b0;
            dexe_clr <= 1'b1;
            dma_irq  <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= gate ? S_WR : S_RD;
          end
        end
        // Request goes out one cycle after entering the state, so a port
        // never sees REQ in the cycle right after its previous ACK.
        S_RD: begin
          if (!src_req) begin
            if (dir) begin
              reg_req <= 1'b1;
              reg_we  <= 1'b0;
              reg_a   <= raddr;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              mem_a   <= maddr;
            end
          end else if (src_ack) begin
            dat     <= src_q;
            mem_req <= 1'b0;
            reg_req <= 1'b0;
            state   <= S_WR;
          end
        end
        S_WR: begin
          if (!dst_req) begin
            if (dir) begin
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              mem_a   <= maddr;
              mem_d   <= gate ? 16'h0000 : dat;
            end else begin
              reg_req <= 1'b1;
              reg_we  <= 1'b1;
              reg_a   <= raddr;
              reg_d   <= gate ? 16'h0000 : dat;
            end
          end else if (dst_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            reg_req <= 1'b0;
            reg_we  <= 1'b0;
            state   <= S_NEXT;
          end
        end
        S_NEXT: begin
          maddr <= maddr + 1'b1;
          raddr <= raddr + 1'b1;
          cnt   <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            busy     <= 1'b0;
            dexe_clr <= 1'b1;
            dma_irq  <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= gate ? S_WR : S_RD;
          end
        end
        // dexe_q keeps tracking here, so an edge landing in DONE is consumed
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scsp_dma_ctrl.sv
// Bench for scsp_dma_ctrl: delayed-ack port responders, a protocol monitor, and
// a word-list reference model of each transfer.
module tb_scsp_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] dmea;
  logic [10:0] drga;
  logic [10:0] dtlg;
  logic        ddir, dgate, dexe;
  logic        dexe_clr, dma_irq, busy;
  logic        mem_req, mem_we, mem_ack;
  logic [18:0] mem_a;
  logic [15:0] mem_d, mem_q;
  logic        reg_req, reg_we, reg_ack;
  logic [10:0] reg_a;
  logic [15:0] reg_d, reg_q;

  logic mack_r, rack_r, stray_m = 1'b0, stray_r = 1'b0;
  assign mem_ack = mack_r | stray_m;
  assign reg_ack = rack_r | stray_r;

  int total = 0, bad = 0;
  int mdly = 0, rdly = 0;
  int mcnt, rcnt;

  scsp_dma_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dmea(dmea), .drga(drga), .dtlg(dtlg),
    .ddir(ddir), .dgate(dgate), .dexe(dexe),
    .dexe_clr(dexe_clr), .dma_irq(dma_irq), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q), .mem_ack(mem_ack),
    .reg_req(reg_req), .reg_we(reg_we), .reg_a(reg_a), .reg_d(reg_d),
    .reg_q(reg_q), .reg_ack(reg_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;   // 0: sound RAM, 1: register window
    bit          we;
    int          a;
    logic [15:0] d;
  } tr_t;

  logic [15:0] ram_init [int];
  tr_t log_q[$];

  function automatic logic [15:0] rdm(input int a);
    if (ram_init.exists(a)) return ram_init[a];
    return 16'(a * 40503 + 4660);
  endfunction

  function automatic logic [15:0] rdr(input int a);
    return 16'((a * 7919) ^ 32'h5A5A);
  endfunction

  function automatic tr_t mk(input bit p, input bit w, input int a, input logic [15:0] d);
    tr_t t;
    t.port = p; t.we = w; t.a = a; t.d = d;
    return t;
  endfunction

  function automatic logic [63:0] pk(input tr_t t);
    return {t.port, t.we, 14'd0, 32'(t.a), t.d};
  endfunction

  // Responders: ack (one cycle) after dly idle cycles of a pending request
  always @(posedge clk) begin
    if (!rst_n) begin
      mack_r <= 1'b0; mcnt <= 0; mem_q <= '0;
    end else begin
      mack_r <= 1'b0;
      if (mem_req && !mack_r) begin
        if (mcnt >= mdly) begin
          mack_r <= 1'b1; mem_q <= rdm(int'(mem_a)); mcnt <= 0;
        end else mcnt <= mcnt + 1;
      end else mcnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      rack_r <= 1'b0; rcnt <= 0; reg_q <= '0;
    end else begin
      rack_r <= 1'b0;
      if (reg_req && !rack_r) begin
        if (rcnt >= rdly) begin
          rack_r <= 1'b1; reg_q <= rdr(int'(reg_a)); rcnt <= 0;
        end else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end
  end

  // Protocol monitor: stability while pending, no re-request right after ack,
  // one port at a time, paired completion pulses, completed-access log.
  int excl_v = 0, stab_v = 0, reas_v = 0, pair_v = 0, clr_n = 0, irq_n = 0;
  logic mpend, macked, rpend, racked, mwe_p, rwe_p;
  logic [18:0] ma_p;
  logic [10:0] ra_p;
  logic [15:0] md_p, rd_p;

  always @(posedge clk) begin
    if (!rst_n) begin
      mpend <= 1'b0; macked <= 1'b0; rpend <= 1'b0; racked <= 1'b0;
    end else begin
      if (mem_req && reg_req) excl_v <= excl_v + 1;
      if (mpend && !(mem_req && mem_we == mwe_p && mem_a == ma_p && mem_d == md_p))
        stab_v <= stab_v + 1;
      if (rpend && !(reg_req && reg_we == rwe_p && reg_a == ra_p && reg_d == rd_p))
        stab_v <= stab_v + 1;
      if ((macked && mem_req) || (racked && reg_req)) reas_v <= reas_v + 1;
      if (dexe_clr !== dma_irq) pair_v <= pair_v + 1;
      if (dexe_clr) clr_n <= clr_n + 1;
      if (dma_irq) irq_n <= irq_n + 1;
      mpend <= mem_req && !mem_ack; macked <= mem_req && mem_ack;
      rpend <= reg_req && !reg_ack; racked <= reg_req && reg_ack;
      mwe_p <= mem_we; ma_p <= mem_a; md_p <= mem_d;
      rwe_p <= reg_we; ra_p <= reg_a; rd_p <= reg_d;
      if (mem_req && mem_ack) log_q.push_back(mk(1'b0, mem_we, int'(mem_a), mem_we ? mem_d : mem_q));
      if (reg_req && reg_ack) log_q.push_back(mk(1'b1, reg_we, int'(reg_a), reg_we ? reg_d : reg_q));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int ea, input int ra, input int n, input bit dir, input bit gate,
                     input bit disturb, input string tag);
    tr_t exq[$];
    logic [15:0] dat;
    int base, c0, i0, v0, cyc, budget, fb, ma, rg;
    for (int i = 0; i < n; i++) begin
      ma = (ea + i) % (1 << 19);
      rg = (ra + i) % (1 << 11);
      dat = 16'h0000;
      if (!gate) begin
        dat = dir ? rdr(rg) : rdm(ma);
        exq.push_back(dir ? mk(1'b1, 1'b0, rg, dat) : mk(1'b0, 1'b0, ma, dat));
      end
      exq.push_back(dir ? mk(1'b0, 1'b1, ma, dat) : mk(1'b1, 1'b1, rg, dat));
    end
    @(negedge clk);
    dmea = 19'(ea); drga = 11'(ra); dtlg = 11'(n); ddir = dir; dgate = gate;
    base = log_q.size(); c0 = clr_n; i0 = irq_n; v0 = excl_v + stab_v + reas_v + pair_v;
    dexe = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_up"}, busy, 1);
    // working copies are latched; these changes must not matter
    @(negedge clk);
    dmea = 19'($urandom); drga = 11'($urandom); dtlg = 11'($urandom);
    ddir = 1'($urandom); dgate = 1'($urandom);
    budget = n * (2 * (mdly + rdly + 6) + 4) + 20;
    cyc = 0;
    while (dexe_clr !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 6) dexe = 1'b0;
      if (disturb && cyc == 8) dexe = 1'b1;
    end
    chk({tag, ".dexe_clr"}, dexe_clr, 1);
    chk({tag, ".irq"}, dma_irq, 1);
    chk({tag, ".busy_done"}, busy, 0);
    if (n == 0) chk({tag, ".zero_latency"}, cyc, 1);
    @(negedge clk);
    dexe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".clr_pulses"}, clr_n - c0, 1);
    chk({tag, ".irq_pulses"}, irq_n - i0, 1);
    chk({tag, ".busy_idle"}, busy, 0);
    chk({tag, ".protocol"}, excl_v + stab_v + reas_v + pair_v - v0, 0);
    chk({tag, ".n_access"}, log_q.size() - base, exq.size());
    fb = exq.size();
    for (int i = 0; i < exq.size(); i++)
      if (base + i >= log_q.size() || pk(log_q[base + i]) != pk(exq[i])) begin
        fb = i;
        break;
      end
    chk({tag, ".first_bad_idx"}, fb, exq.size());
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; dexe = 1'b0; dmea = '0; drga = '0; dtlg = '0; ddir = 1'b0; dgate = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctl", {dexe_clr, dma_irq, busy, mem_req, mem_we, reg_req, reg_we}, 0);
    chk("reset.bus", {mem_a, mem_d, reg_a, reg_d}, 0);
    @(negedge clk) rst_n = 1'b1;

    // stray acks in IDLE must be ignored
    @(negedge clk) begin stray_m = 1'b1; stray_r = 1'b1; end
    @(negedge clk) begin stray_m = 1'b0; stray_r = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    chk("stray.busy", busy, 0);
    chk("stray.log", log_q.size(), 0);

    ram_init[32'h100] = 16'h1111; ram_init[32'h101] = 16'h2222;
    ram_init[32'h102] = 16'h3333; ram_init[32'h103] = 16'h4444;
    run(32'h100, 32'h300, 4, 1'b0, 1'b0, 1'b0, "t1");
    chk("t1.last_wr", pk(log_q[log_q.size() - 1]), pk(mk(1'b1, 1'b1, 32'h303, 16'h4444)));
    run(32'h7FFFF, 32'h7FF, 2, 1'b1, 1'b0, 1'b0, "t2");
    chk("t2.wrap_wr", pk(log_q[log_q.size() - 1]), pk(mk(1'b0, 1'b1, 0, rdr(0))));
    run(32'h1234, 32'h55, 3, 1'b0, 1'b1, 1'b0, "t3");
    run(32'h42, 32'h10, 0, 1'b1, 1'b0, 1'b0, "t4");
    mdly = 5;
    run(32'h2000, 32'h120, 6, 1'b0, 1'b0, 1'b1, "t5");
    mdly = 0;

    // reset while a register write is outstanding
    rdly = 30;
    @(negedge clk);
    dmea = 19'h300; drga = 11'h40; dtlg = 11'd3; ddir = 1'b0; dgate = 1'b0; dexe = 1'b1;
    cyc = 0;
    while (!(reg_req && reg_we) && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("t6.wr_pending", reg_req && reg_we, 1);
    cyc = clr_n;
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_ctl", {dexe_clr, dma_irq, busy, mem_req, mem_we, reg_req, reg_we}, 0);
    chk("t6.rst_bus", {mem_a, mem_d, reg_a, reg_d}, 0);
    dexe = 1'b0;
    rdly = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6.no_pulse", clr_n - cyc, 0);
    run(32'h300, 32'h40, 3, 1'b0, 1'b0, 1'b0, "t6.restart");

    for (int k = 0; k < 8; k++) begin
      mdly = $urandom_range(0, 3);
      rdly = $urandom_range(0, 3);
      run(($urandom_range(0, 1) != 0) ? int'($urandom_range(32'h7FFF0, 32'h7FFFF)) : int'($urandom_range(0, 32'h7FFFF)),
          int'($urandom_range(0, 32'h7FF)), int'($urandom_range(0, 24)),
          1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
    end

    mdly = 0; rdly = 0;
    run(int'($urandom_range(0, 32'h7FFFF)), int'($urandom_range(0, 32'h7FF)), 2047, 1'b0, 1'b0, 1'b0, "max");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
